// File: rtl/issue_fifo.sv
// issue_fifo: in-order buffer between decode and the reorder/issue stage.
//   Decoded entries are pushed when ack is high. The head and the entry
//   behind it (lookahead) are presented to the issue stage. Counts of stored
//   entries and of stored LOAD/STORE entries are exported.
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   flush_i                 drop all stored entries
//   decoded_entry_i/_valid_i, is_ctrl_flow_i, decoded_entry_ack_o  write side
//   issue_entry_o/_valid_o, is_ctrl_flow_o, issue_instr_ack_i      head
//   next_entry_o/_valid_o   lookahead (slot behind head)
//   mem_op_cnt_o, count_o   occupancy counters

package ariane_pkg;
  typedef enum logic [3:0] {
    NONE = 4'd0, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR
  } fu_t;

  typedef struct packed {
    logic [31:0] pc;
    fu_t         fu;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } scoreboard_entry_t;
endpackage

module issue_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  ariane_pkg::scoreboard_entry_t     decoded_entry_i,
  input  logic                              decoded_entry_valid_i,
  input  logic                              is_ctrl_flow_i,
  output logic                              decoded_entry_ack_o,
  output ariane_pkg::scoreboard_entry_t     issue_entry_o,
  output logic                              issue_entry_valid_o,
  output logic                              is_ctrl_flow_o,
  input  logic                              issue_instr_ack_i,
  output ariane_pkg::scoreboard_entry_t     next_entry_o,
  output logic                              next_entry_valid_o,
  output logic [$clog2(DEPTH):0]            mem_op_cnt_o,
  output logic [$clog2(DEPTH):0]            count_o
);
  import ariane_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  scoreboard_entry_t mem_q  [DEPTH];
  scoreboard_entry_t mem_d  [DEPTH];
  logic [DEPTH-1:0]  ctrl_q, ctrl_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d, wptr_q, wptr_d, nptr;
  logic [CNT_W-1:0]  cnt_q, cnt_d, mcnt_q, mcnt_d;

  logic push, pop, ack, head_vld, push_mem, pop_mem;

  always_comb begin
    ack      = (cnt_q != FULL) & ~flush_i;
    head_vld = (cnt_q != '0);
    // Fullness is judged before any same-cycle pop, so a full FIFO never
    // accepts even while the head is leaving.
    push     = decoded_entry_valid_i & ack;
    pop      = head_vld & issue_instr_ack_i & ~flush_i;
    nptr     = rptr_q + PTR_W'(1);
    push_mem = push & (decoded_entry_i.fu inside {LOAD, STORE});
    pop_mem  = pop & (mem_q[rptr_q].fu inside {LOAD, STORE});

    mem_d  = mem_q;
    ctrl_d = ctrl_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    mcnt_d = mcnt_q;

    if (flush_i) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
      mcnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q]  = decoded_entry_i;
        ctrl_d[wptr_q] = is_ctrl_flow_i;
        wptr_d         = wptr_q + PTR_W'(1);
      end
      if (pop) rptr_d = nptr;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      case ({push_mem, pop_mem})
        2'b10:   mcnt_d = mcnt_q + CNT_W'(1);
        2'b01:   mcnt_d = mcnt_q - CNT_W'(1);
        default: mcnt_d = mcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ctrl_q <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      mcnt_q <= '0;
    end else begin
      mem_q  <= mem_d;
      ctrl_q <= ctrl_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  // Outputs read registered slots only: no empty bypass.
  always_comb begin
    decoded_entry_ack_o = ack;
    issue_entry_valid_o = head_vld;
    next_entry_valid_o  = (cnt_q >= CNT_W'(2));
    issue_entry_o       = head_vld ? mem_q[rptr_q] : '0;
    is_ctrl_flow_o      = head_vld ? ctrl_q[rptr_q] : 1'b0;
    next_entry_o        = next_entry_valid_o ? mem_q[nptr] : '0;
    count_o             = cnt_q;
    mem_op_cnt_o        = mcnt_q;
  end

endmodule

// File: tb/tb_issue_fifo.sv
// Bench for issue_fifo: directed scenarios followed by random traffic.
// A monitor keeps a queue of expected entries and checks every DUT output
// each cycle; directed phases add point checks of their own.
module tb_issue_fifo;
  import ariane_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
  scoreboard_entry_t decoded_entry_i = '0;
  logic decoded_entry_valid_i = 1'b0, is_ctrl_flow_i = 1'b0, issue_instr_ack_i = 1'b0;
  logic decoded_entry_ack_o, issue_entry_valid_o, is_ctrl_flow_o, next_entry_valid_o;
  scoreboard_entry_t issue_entry_o, next_entry_o;
  logic [CW-1:0] mem_op_cnt_o, count_o;

  issue_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .decoded_entry_i(decoded_entry_i), .decoded_entry_valid_i(decoded_entry_valid_i),
    .is_ctrl_flow_i(is_ctrl_flow_i), .decoded_entry_ack_o(decoded_entry_ack_o),
    .issue_entry_o(issue_entry_o), .issue_entry_valid_o(issue_entry_valid_o),
    .is_ctrl_flow_o(is_ctrl_flow_o), .issue_instr_ack_i(issue_instr_ack_i),
    .next_entry_o(next_entry_o), .next_entry_valid_o(next_entry_valid_o),
    .mem_op_cnt_o(mem_op_cnt_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct { scoreboard_entry_t e; logic c; } item_t;
  item_t exp_q[$];
  int errors = 0, checks = 0;
  bit mon_en = 1'b0;
  int unsigned pc_ctr = 32'h100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic scoreboard_entry_t mk(input fu_t fu);
    scoreboard_entry_t e;
    e.pc  = pc_ctr;
    e.fu  = fu;
    e.op  = 8'($urandom);
    e.rs1 = 5'($urandom);
    e.rs2 = 5'($urandom);
    e.rd  = 5'($urandom);
    pc_ctr += 4;
    return e;
  endfunction

  // Reference model: a plain queue. Check outputs against the queue state
  // before the edge, then apply the cycle's push/pop/flush/reset to it.
  always @(negedge clk) begin
    if (mon_en) begin
      int n, m;
      bit do_pop;
      n = exp_q.size();
      m = 0;
      foreach (exp_q[i]) if (exp_q[i].e.fu inside {LOAD, STORE}) m++;
      chk("ack_o",      decoded_entry_ack_o, (n != DEPTH) && !flush_i);
      chk("count_o",    count_o, n);
      chk("mem_op_cnt", mem_op_cnt_o, m);
      chk("valid_o",    issue_entry_valid_o, n != 0);
      chk("head",       issue_entry_o, n != 0 ? exp_q[0].e : '0);
      chk("head_ctrl",  is_ctrl_flow_o, n != 0 ? exp_q[0].c : 1'b0);
      chk("next_valid", next_entry_valid_o, n >= 2);
      chk("next",       next_entry_o, n >= 2 ? exp_q[1].e : '0);
      if (!rst_ni || flush_i) exp_q.delete();
      else begin
        do_pop = (n != 0) && issue_instr_ack_i;
        if (decoded_entry_valid_i && n < DEPTH)
          exp_q.push_back('{e: decoded_entry_i, c: is_ctrl_flow_i});
        if (do_pop) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    decoded_entry_valid_i = 1'b0; issue_instr_ack_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic push1(input fu_t fu, input logic c);
    decoded_entry_i = mk(fu); is_ctrl_flow_i = c; decoded_entry_valid_i = 1'b1;
    step();
    decoded_entry_valid_i = 1'b0;
  endtask

  scoreboard_entry_t a, b;

  initial begin
    // Reset
    step(); step();
    rst_ni = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_count", count_o, 0);
    chk("rst_ack", decoded_entry_ack_o, 1);
    chk("rst_head", issue_entry_o, 0);
    step();

    // Fill with ack held low; fifth push must be refused
    push1(ALU, 1'b0); a = exp_q[0].e;
    push1(CTRL_FLOW, 1'b1); b = exp_q[1].e;
    push1(MULT, 1'b0);
    push1(CSR, 1'b1);
    @(negedge clk);
    chk("fill_count", count_o, 4);
    chk("fill_ack", decoded_entry_ack_o, 0);
    chk("fill_head", issue_entry_o, a);
    chk("fill_next", next_entry_o, b);
    step();
    push1(ALU, 1'b0);
    @(negedge clk);
    chk("fifth_refused", count_o, 4);
    step();

    // Full with push and pop together: only the pop happens
    decoded_entry_i = mk(LOAD); decoded_entry_valid_i = 1'b1; issue_instr_ack_i = 1'b1;
    step(); idle();
    @(negedge clk);
    chk("full_pp_count", count_o, 3);
    chk("full_pp_head", issue_entry_o, b);
    step();

    // Flush with concurrent push/pop
    flush_i = 1'b1; decoded_entry_i = mk(STORE); decoded_entry_valid_i = 1'b1; issue_instr_ack_i = 1'b1;
    step(); idle();
    @(negedge clk);
    chk("flush_count", count_o, 0);
    chk("flush_valid", issue_entry_valid_o, 0);
    step();

    // mem op counting
    push1(LOAD, 1'b0); push1(ALU, 1'b0); push1(STORE, 1'b0);
    @(negedge clk);
    chk("memop_cnt3", mem_op_cnt_o, 2);
    chk("memop_count", count_o, 3);
    step();
    issue_instr_ack_i = 1'b1; step(); issue_instr_ack_i = 1'b0;
    @(negedge clk);
    chk("memop_after_pop", mem_op_cnt_o, 1);
    chk("memop_head_alu", issue_entry_o.fu, ALU);
    step();
    issue_instr_ack_i = 1'b1; step(); step(); idle();

    // Wrap: stream ten push/pop pairs at occupancy one
    push1(ALU, 1'b0);
    for (int i = 0; i < 10; i++) begin
      decoded_entry_i = mk(fu_t'($urandom_range(1, 6))); is_ctrl_flow_i = 1'($urandom);
      decoded_entry_valid_i = 1'b1; issue_instr_ack_i = 1'b1;
      @(negedge clk);
      chk("wrap_count", count_o, 1);
      step();
    end
    idle();

    // Reset mid-operation with two entries stored
    push1(LOAD, 1'b1);
    @(negedge clk);
    chk("pre_rst_count", count_o, 2);
    step();
    rst_ni = 1'b0; decoded_entry_valid_i = 1'b1; issue_instr_ack_i = 1'b1;
    step(); idle(); rst_ni = 1'b1;
    @(negedge clk);
    chk("midrst_count", count_o, 0);
    chk("midrst_next", next_entry_o, 0);
    chk("midrst_ack", decoded_entry_ack_o, 1);
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      decoded_entry_i       = mk(fu_t'($urandom_range(0, 6)));
      is_ctrl_flow_i        = 1'($urandom);
      decoded_entry_valid_i = ($urandom_range(0, 99) < 60);
      issue_instr_ack_i     = ($urandom_range(0, 99) < 45);
      flush_i               = ($urandom_range(0, 99) < 3);
      rst_ni                = ($urandom_range(0, 199) != 0);
      step();
    end
    idle(); rst_ni = 1'b1;
    step();
    @(negedge clk);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
